// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB requester bridge.
package apb_master_pkg;

    localparam int APB_ADDR_W         = 32;
    localparam int APB_DATA_W         = 32;
    localparam int APB_WAIT_W         = 8;
    localparam int APB_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 requester: one command in, one APB transfer out, one response back.
// Optional wait-state timeout is enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int WAIT_W         = APB_WAIT_W,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [WAIT_W-1:0] rsp_waits,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [WAIT_W-1:0] cnt_inc;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [WAIT_W-1:0] waits_q, waits_d;
    logic              err_q, err_d;
    logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    // One extra bit so a limit equal to the saturation value is still reachable.
    localparam logic [WAIT_W:0] TO_LIM = TIMEOUT_CYCLES[WAIT_W:0];
    assign timeout_hit = !PREADY && ({1'b0, cnt_inc} >= TO_LIM);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        waits_d  = waits_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    if (cmd_write) pwdata_d = cmd_wdata;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    waits_d = cnt_q;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    cnt_d   = cnt_inc;
                    rdata_d = '0;
                    waits_d = cnt_inc;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            waits_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            waits_q  <= waits_d;
            err_q    <= err_d;
        end
    end

    // Handshake and bus-phase strobes decode straight from the registered state.
    assign cmd_ready = (state_q == ST_IDLE);
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign rsp_valid = (state_q == ST_RESP);
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_waits = waits_q;
    assign rsp_err   = err_q;

endmodule
